cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 2: number of cycles cpu_reset is held after reset deasserts (legal range 1..255).
REQ-002 Parameter MAX_CYCLES, default 100000: run-cycle budget before timeout (legal value ≥ 2).
REQ-003 Parameter STALL_LIMIT, default 4: number of consecutive unchanged-PC cycles that signal halt (legal value ≥ 1).
REQ-004 Parameter PC_W, default 32: PC width.
REQ-005 Parameter CNT_W, default 32: counter width; must hold MAX_CYCLES.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse that re-arms the block from DONE or TIMEOUT.
REQ-010 pc  in  PC_W  current PC of the controlled CPU.
REQ-011 reg_we  in  1  CPU register-file write enable; used only when the feature in REQ-030 is compiled in.
REQ-012 cpu_reset  out  1  reset driven to the CPU.
REQ-013 run  out  1  high while the CPU is executing.
REQ-014 done  out  1  sticky flag: halt was detected.
REQ-015 timeout  out  1  sticky flag: the cycle budget is exhausted.
REQ-016 cycle_count  out  CNT_W  number of RUN cycles.
REQ-017 halt_pc  out  PC_W  PC captured when halt is detected.
REQ-018 wb_count  out  CNT_W  count of register writebacks (see REQ-030).

Function
REQ-019 The FSM shall have states RST_HOLD, RUN, DONE and TIMEOUT, with registered outputs decoded from state.
- RST_HOLD: cpu_reset=1, run=0.
- RUN: cpu_reset=0, run=1.
- DONE/TIMEOUT: cpu_reset=0, run=0.
REQ-020 RST_HOLD shall increment hold_cnt every cycle and enter RUN on the edge where hold_cnt==RESET_CYCLES-1, so that cpu_reset stays high for exactly RESET_CYCLES cycles after reset falls.
REQ-021 In RUN, cycle_count shall increment by 1 every cycle.
REQ-022 In RUN, the block shall compare pc with prev_pc.
- Equal: stall_cnt increments.
- Different: stall_cnt clears.
- The first RUN cycle shall not compare, because prev_pc is not yet valid.
REQ-023 When stall_cnt reaches STALL_LIMIT, the block shall enter DONE, set done=1 and load halt_pc from pc on that same edge.
REQ-024 When cycle_count would reach MAX_CYCLES, the block shall enter TIMEOUT and set timeout=1; cycle_count shall saturate at MAX_CYCLES.
REQ-025 If halt and timeout occur on the same edge, the block shall enter DONE only (done=1, timeout=0).
REQ-026 In DONE and TIMEOUT, cycle_count, halt_pc and wb_count shall hold their values.
REQ-027 start shall be honoured only in DONE or TIMEOUT.
- On start, the block enters RST_HOLD and clears hold_cnt, stall_cnt, cycle_count, wb_count, done, timeout and halt_pc.
- start in RST_HOLD or RUN shall be ignored.
REQ-028 reset shall have priority over start and over every state transition.

Reset
REQ-029 While reset=1, on each edge the block shall set:
- state=RST_HOLD, cpu_reset=1, run=0, done=0, timeout=0;
- cycle_count=0, halt_pc=0, wb_count=0, hold_cnt=0, stall_cnt=0, prev_pc valid=0.
Reset asserted mid-RUN shall abort the run and apply the same values.

Configuration
REQ-030 Macro CPU_RUN_CTRL_WBCNT_EN:
- Defined: wb_count increments in RUN on each cycle with reg_we=1, saturating at all-ones.
- Undefined: wb_count is tied to 0, reg_we is ignored, and no counter logic is synthesised.

Verification
REQ-031 RESET_CYCLES=3; reset high 2 cycles, then low -> cpu_reset high for exactly 3 edges after reset falls, run=1 on the 4th edge.
REQ-032 STALL_LIMIT=4; pc=0x3000,0x3004,0x3008, then held at 0x3008 -> done=1 and halt_pc=0x3008 after the 4th repeat; cycle_count frozen at 7; run=0.
REQ-033 MAX_CYCLES=10; pc increments every cycle -> timeout=1 with cycle_count=10, done=0, run=0.
REQ-034 MAX_CYCLES=10, STALL_LIMIT=1; pc constant from cycle 8 so halt lands on the budget edge -> done=1, timeout=0.
REQ-035 In DONE, pulse start -> RST_HOLD with all counters and flags cleared; a start pulse during RUN -> no effect.
REQ-036 With CPU_RUN_CTRL_WBCNT_EN defined, reg_we high on 5 of 8 RUN cycles -> wb_count=5; without the macro -> wb_count=0; reset asserted mid-RUN -> values per REQ-029 on the next edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds CPU reset, then runs until halt or cycle budget.
// Optional writeback counter enabled by defining CPU_RUN_CTRL_WBCNT_EN.
module cpu_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100000,
  parameter int STALL_LIMIT  = 4,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             reg_we,
  output logic             cpu_reset,
  output logic             run,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] wb_count
);

  localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] STALL_C   = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ST_RST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
`ifdef CPU_RUN_CTRL_WBCNT_EN
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    cycle_count_d = cycle_count_q;
    prev_pc_d     = prev_pc_q;
    prev_vld_d    = prev_vld_q;
    halt_pc_d     = halt_pc_q;
`ifdef CPU_RUN_CTRL_WBCNT_EN
    wb_cnt_d      = wb_cnt_q;
`endif
    case (state_q)
      ST_RST_HOLD: begin
        hold_cnt_d  = hold_cnt_q + 8'd1;
        prev_vld_d  = 1'b0;
        stall_cnt_d = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cycle_count_d = cycle_count_q + 1'b1;
        prev_pc_d     = pc;
        prev_vld_d    = 1'b1;
        // The first RUN cycle has no valid previous PC, so it never counts as a stall.
        if (prev_vld_q && (pc == prev_pc_q)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          stall_cnt_d = '0;
        end
`ifdef CPU_RUN_CTRL_WBCNT_EN
        if (reg_we && (wb_cnt_q != '1)) begin
          wb_cnt_d = wb_cnt_q + 1'b1;
        end
`endif
        // Halt wins over an exhausted budget landing on the same edge.
        if (stall_cnt_d == STALL_C) begin
          state_d   = ST_DONE;
          halt_pc_d = pc;
        end else if (cycle_count_d == MAX_C) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d       = ST_RST_HOLD;
          hold_cnt_d    = '0;
          stall_cnt_d   = '0;
          cycle_count_d = '0;
          prev_vld_d    = 1'b0;
          halt_pc_d     = '0;
`ifdef CPU_RUN_CTRL_WBCNT_EN
          wb_cnt_d      = '0;
`endif
        end
      end
    endcase
    cpu_reset_d = (state_d == ST_RST_HOLD);
    run_d       = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    timeout_d   = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST_HOLD;
      hold_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      cycle_count_q <= '0;
      prev_pc_q     <= '0;
      prev_vld_q    <= 1'b0;
      halt_pc_q     <= '0;
      cpu_reset_q   <= 1'b1;
      run_q         <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef CPU_RUN_CTRL_WBCNT_EN
      wb_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      cycle_count_q <= cycle_count_d;
      prev_pc_q     <= prev_pc_d;
      prev_vld_q    <= prev_vld_d;
      halt_pc_q     <= halt_pc_d;
      cpu_reset_q   <= cpu_reset_d;
      run_q         <= run_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
`ifdef CPU_RUN_CTRL_WBCNT_EN
      wb_cnt_q      <= wb_cnt_d;
`endif
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign run         = run_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign halt_pc     = halt_pc_q;

`ifdef CPU_RUN_CTRL_WBCNT_EN
  assign wb_count = wb_cnt_q;
`else
  logic unused_reg_we;
  assign unused_reg_we = reg_we;
  assign wb_count      = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomised and directed bench for cpu_run_ctrl against a queue-based behavioural model.
module tb_cpu_run_ctrl;
  localparam int RC = 3;
  localparam int MC = 10;
  localparam int SL = 4;
  localparam int PW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, reg_we;
  logic [PW-1:0] pc;
  logic          cpu_reset, run, done, timeout;
  logic [CW-1:0] cycle_count, wb_count;
  logic [PW-1:0] halt_pc;

  cpu_run_ctrl #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .STALL_LIMIT(SL), .PC_W(PW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .reg_we(reg_we),
    .cpu_reset(cpu_reset), .run(run), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .halt_pc(halt_pc), .wb_count(wb_count)
  );

  int n_vec = 0;
  int n_err = 0;

`ifdef CPU_RUN_CTRL_WBCNT_EN
  localparam int WB_EXP = 5;
`else
  localparam int WB_EXP = 0;
`endif

  // Model: phase flags, elapsed hold cycles, and the list of PCs seen in this run.
  bit            m_hold, m_run, m_done, m_to;
  int            m_elapsed;
  logic [PW-1:0] m_pcs[$];
  logic [PW-1:0] m_halt;
  int            m_wb;

  function automatic void m_clear();
    m_hold = 1'b1; m_run = 1'b0; m_done = 1'b0; m_to = 1'b0;
    m_elapsed = 0; m_pcs.delete(); m_halt = '0; m_wb = 0;
  endfunction

  function automatic void m_edge();
    int reps;
    if (reset) begin
      m_clear();
    end else if (m_done || m_to) begin
      if (start) m_clear();
    end else if (m_hold) begin
      m_elapsed++;
      if (m_elapsed == RC) begin
        m_hold = 1'b0;
        m_run  = 1'b1;
      end
    end else begin
      m_pcs.push_back(pc);
`ifdef CPU_RUN_CTRL_WBCNT_EN
      if (reg_we && m_wb < (1 << CW) - 1) m_wb++;
`endif
      reps = 0;
      for (int i = m_pcs.size() - 1; i > 0; i--) begin
        if (m_pcs[i] == m_pcs[i-1]) reps++;
        else break;
      end
      if (reps == SL) begin
        m_run = 1'b0; m_done = 1'b1; m_halt = pc;
      end else if (m_pcs.size() == MC) begin
        m_run = 1'b0; m_to = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cpu_reset",   64'(cpu_reset),   64'(m_hold));
    chk("run",         64'(run),         64'(m_run));
    chk("done",        64'(done),        64'(m_done));
    chk("timeout",     64'(timeout),     64'(m_to));
    chk("cycle_count", 64'(cycle_count), 64'(m_pcs.size()));
    chk("halt_pc",     64'(halt_pc),     64'(m_halt));
    chk("wb_count",    64'(wb_count),    64'(m_wb));
  endtask

  task automatic step(input logic r, input logic s, input logic [PW-1:0] p, input logic w);
    reset = r; start = s; pc = p; reg_we = w;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold3();
    for (int i = 0; i < RC; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  logic [PW-1:0] s2_pcs [7];
  logic [7:0]    we_pat;

  initial begin
    reset = 1'b1; start = 1'b0; pc = '0; reg_we = 1'b0;
    m_clear();
    @(negedge clk);

    // Reset for two cycles, then the CPU reset hold
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("lit_rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("lit_rst_cycles",    64'(cycle_count), 64'd0);
    for (int i = 0; i < RC; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      if (i < RC - 1) chk("lit_hold_cpu_reset", 64'(cpu_reset), 64'd1);
      else            chk("lit_hold_run",       64'(run),       64'd1);
    end

    // Halt after four repeats of 0x3008; start during RUN must be ignored
    s2_pcs = '{16'h3000, 16'h3004, 16'h3008, 16'h3008, 16'h3008, 16'h3008, 16'h3008};
    for (int i = 0; i < 7; i++) step(1'b0, (i == 1), s2_pcs[i], 1'b0);
    chk("lit_halt_done",   64'(done),        64'd1);
    chk("lit_halt_pc",     64'(halt_pc),     64'h3008);
    chk("lit_halt_cycles", 64'(cycle_count), 64'd7);
    chk("lit_halt_run",    64'(run),         64'd0);
    step(1'b0, 1'b0, 16'h1234, 1'b1);
    chk("lit_done_frozen", 64'(cycle_count), 64'd7);

    // Start from DONE clears everything
    step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("lit_start_cpu_reset", 64'(cpu_reset),   64'd1);
    chk("lit_start_done",      64'(done),        64'd0);
    chk("lit_start_cycles",    64'(cycle_count), 64'd0);
    chk("lit_start_halt_pc",   64'(halt_pc),     64'd0);
    hold3();

    // Budget exhaustion with an always-advancing PC
    for (int i = 0; i < MC; i++) step(1'b0, 1'b0, 16'(i * 4), 1'b0);
    chk("lit_to_timeout", 64'(timeout),     64'd1);
    chk("lit_to_cycles",  64'(cycle_count), 64'd10);
    chk("lit_to_done",    64'(done),        64'd0);
    chk("lit_to_run",     64'(run),         64'd0);

    // Halt landing on the budget edge: DONE only
    step(1'b0, 1'b1, 16'h0, 1'b0);
    hold3();
    for (int i = 0; i < MC; i++) step(1'b0, 1'b0, (i < 6) ? 16'(16'h100 + i * 4) : 16'h114, 1'b0);
    chk("lit_tie_done",    64'(done),        64'd1);
    chk("lit_tie_timeout", 64'(timeout),     64'd0);
    chk("lit_tie_cycles",  64'(cycle_count), 64'd10);

    // Writebacks on 5 of 8 RUN cycles, then reset mid-RUN
    step(1'b0, 1'b1, 16'h0, 1'b0);
    hold3();
    we_pat = 8'b1011_0101;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'(16'h200 + i * 4), we_pat[i]);
    chk("lit_wb_count", 64'(wb_count), 64'(WB_EXP));
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("lit_abort_cpu_reset", 64'(cpu_reset),   64'd1);
    chk("lit_abort_run",       64'(run),         64'd0);
    chk("lit_abort_cycles",    64'(cycle_count), 64'd0);
    chk("lit_abort_wb",        64'(wb_count),    64'd0);

    // Random traffic with a small PC alphabet so stalls, halts and timeouts all occur
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
           16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
